ps2_rx_fifo: RTL and testbench
==============================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered scan codes (power of two, 2..32).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, number of clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock (100 MHz CPU domain); single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data pin, asynchronous.
REQ-007 SHALL have port code_data  output  8  scan code at FIFO head.
REQ-008 SHALL have port code_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port code_ready  input  1  consumer (keyboard register logic) accepts head this cycle.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky: byte dropped because FIFO full.
REQ-012 SHALL have port overflow_clr  input  1  clears overflow.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a rejected or timed-out frame.

Function
REQ-014 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; a falling edge SHALL be detected when the previous synchronized ps2_clk is 1 and the current is 0 (pin edge to detection: 3 clk cycles).
REQ-015 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on detected falling edges, sampling synchronized ps2_data at the edge.
REQ-016 IDLE: sampled 0 (start bit) -> DATA with bit counter 0; sampled 1 -> stay IDLE, no error.
REQ-017 DATA: shift bits LSB-first; after the 8th bit -> PARITY.
REQ-018 PARITY: store parity bit -> STOP.
REQ-019 STOP: frame good when stop bit is 1 (and parity ok per REQ-031); good frame SHALL push the byte in the same cycle; bad frame SHALL pulse frame_err in the same cycle and push nothing; -> IDLE either way.
REQ-020 SHALL reset the timeout counter on every detected falling edge and hold it at 0 in IDLE; when it reaches TIMEOUT_CYCLES-1 outside IDLE, FSM SHALL return to IDLE, discard the partial byte and pulse frame_err.
REQ-021 FIFO SHALL be first-word-fall-through: code_data = head entry while code_valid=1, 8'h00 while empty; pushed byte visible on code_valid/code_data the cycle after the push.
REQ-022 Pop SHALL occur when code_valid && code_ready; code_ready while empty SHALL be ignored.
REQ-023 Push when full without simultaneous pop SHALL drop the new byte, keep contents, set overflow.
REQ-024 Simultaneous push and pop SHALL both take effect (count unchanged), including when full.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-026 overflow_clr SHALL clear overflow next cycle; a simultaneous overflow event SHALL take priority (overflow stays 1).

Reset
REQ-027 reset_n=0 at a clk rising edge SHALL force: FSM IDLE, bit counter 0, timeout counter 0, FIFO empty, fifo_count 0, code_valid 0, code_data 8'h00, overflow 0, frame_err 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; reception SHALL resume at the next start bit after release.
REQ-029 Bytes in the FIFO at reset SHALL be lost.

Configuration
REQ-030 Macro PS2_PARITY_CHECK_EN SHALL select parity checking.
REQ-031 Defined: frame good only if the 8 data bits plus parity bit have odd parity; otherwise rejected with frame_err. Undefined: parity bit sampled and ignored; only stop bit checked.

Verification
REQ-032 Send frame 0x1C with correct parity, code_ready=0 -> code_valid=1, code_data=8'h1C, fifo_count=1, frame_err never asserted.
REQ-033 Send 0x1C, 0xF0, 0x1C then hold code_ready=1 -> three pops in order 1C, F0, 1C, then code_valid=0, code_data=8'h00.
REQ-034 Send 9 frames with code_ready=0, FIFO_DEPTH=8 -> fifo_count=8, overflow=1, head=first byte; pulse overflow_clr -> overflow=0.
REQ-035 Send 0x29 with wrong parity -> with PS2_PARITY_CHECK_EN: frame_err pulse, fifo_count=0; without: code_data=8'h29.
REQ-036 Send start bit plus 3 data bits then stop ps2_clk -> frame_err pulse after TIMEOUT_CYCLES; subsequent full 0x5A frame received correctly.
REQ-037 Assert reset_n=0 for one cycle mid-frame with 2 bytes queued -> fifo_count=0, code_valid=0; next frame 0x76 received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deframes 11-bit frames and queues scan codes in a FWFT FIFO.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection; without it only the stop bit is checked.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    code_data,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic odd_parity9(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          code_valid_q, code_valid_d;
  logic [7:0]    code_data_q, code_data_d;
  logic          fall_s, timeout_s, push_s, pop_s, full_s, push_ok_s, parity_ok_s;
`ifdef PS2_PARITY_CHECK_EN
  logic          parity_q, parity_d;
`endif

  // Two-flop synchronizers plus one delayed copy of the clock for edge detection.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    fall_s     = clk_prev_q & ~clk_s2_q;
  end

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok_s = odd_parity9(shift_q, parity_q);
`else
  assign parity_ok_s = 1'b1;
`endif

  // Frame deserializer FSM with inactivity timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_s      = 1'b0;
    timeout_s   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d    = parity_q;
`endif
    if (state_q == S_IDLE) begin
      to_cnt_d = {TW{1'b0}};
    end else if (fall_s) begin
      to_cnt_d = {TW{1'b0}};
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d  = {TW{1'b0}};
      timeout_s = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (fall_s && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall_s) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (fall_s) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = dat_s2_q;
`endif
          state_d  = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (fall_s) begin
          state_d = S_IDLE;
          if (dat_s2_q && parity_ok_s) begin
            push_s = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_s) begin
      state_d     = S_IDLE;
      bit_cnt_d   = 3'd0;
      shift_d     = 8'h00;
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_d;
    end
  end

  // FWFT FIFO bookkeeping; the head output is precomputed from next-state values so it can be registered.
  always_comb begin
    full_s    = (count_q == FULL_CNT);
    pop_s     = code_valid_q & code_ready;
    push_ok_s = push_s & (~full_s | pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    code_valid_d = (count_d != {CW{1'b0}});
    if (code_valid_d) begin
      code_data_d = mem_d[rd_ptr_d];
    end else begin
      code_data_d = 8'h00;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      to_cnt_q     <= {TW{1'b0}};
      frame_err_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      overflow_q   <= 1'b0;
      code_valid_q <= 1'b0;
      code_data_q  <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      clk_prev_q   <= clk_prev_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      frame_err_q  <= frame_err_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      code_valid_q <= code_valid_d;
      code_data_q  <= code_data_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign code_data  = code_data_q;
  assign code_valid = code_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed + randomized bench for ps2_rx_fifo against a queue-based frame model.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TO    = 300;

  logic       clk = 1'b0;
  logic       reset_n, ps2_clk, ps2_data, code_ready, overflow_clr;
  logic [7:0] code_data;
  logic       code_valid, overflow, frame_err;
  logic [3:0] fifo_count;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int ferr_seen = 0, exp_ferr = 0;
  logic exp_ovf = 1'b0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr),
    .frame_err(frame_err));

  always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic good_frame(input logic [7:0] b, input logic par, input logic stp);
`ifdef PS2_PARITY_CHECK_EN
    return stp && ((^b ^ par) == 1'b1);
`else
    return stp;
`endif
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nb);
    for (int i = 0; i < nb; i++) begin
      ps2_data = f[i];
      wait_cyc(7);
      ps2_clk = 1'b0;
      wait_cyc(15);
      ps2_clk = 1'b1;
      wait_cyc(8);
    end
    ps2_data = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bits({stp, par, b, 1'b0}, 11);
    if (good_frame(b, par, stp)) begin
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~(^b), 1'b1);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, "_valid"}, 32'(code_valid), 32'(q.size() != 0));
    chk({tag, "_data"}, 32'(code_data), 32'(head));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_pop_valid"}, 32'(code_valid), 32'd1);
    chk({tag, "_pop_data"}, 32'(code_data), 32'(q[0]));
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    q.delete(0);
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_one(tag);
    check_state({tag, "_drained"});
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    code_ready = 1'b0; overflow_clr = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    check_state("reset");
    chk("reset_frame_err", 32'(frame_err), 32'd0);

    send_good(8'h1C);
    check_state("single_1c");

    send_good(8'hF0);
    send_good(8'h1C);
    check_state("three_queued");
    drain("three");

    for (int i = 0; i < DEPTH + 1; i++) send_good(8'(8'h10 + 8'(i * 7)));
    check_state("overflow");
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    check_state("ovf_clr");
    drain("ovf");

    code_ready = 1'b1;
    wait_cyc(3);
    code_ready = 1'b0;
    check_state("ready_empty");

    send_frame(8'h29, 1'b1, 1'b1);
    check_state("bad_parity_29");
    drain("parity");

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       send_frame(b, ~(^b), 1'b0);
        1:       send_frame(b, ^b, 1'b1);
        default: send_good(b);
      endcase
      check_state("rand_frame");
      if (q.size() != 0 && $urandom_range(0, 1) == 1) pop_one("rand");
    end
    drain("rand");

    send_bits({3'b111, 8'h5A, 1'b0}, 4);
    wait_cyc(TO + 20);
    exp_ferr++;
    check_state("timeout");
    send_good(8'h5A);
    check_state("after_timeout_5a");
    drain("timeout");

    send_good(8'h11);
    send_good(8'h22);
    send_bits({3'b111, 8'h33, 1'b0}, 4);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    exp_ovf = 1'b0;
    check_state("mid_frame_reset");
    send_good(8'h76);
    check_state("after_reset_76");
    drain("reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
